// File: rtl/if_stage_pkg.sv
// Shared widths, stall encoding and fetch-state type for the MIPS instruction-fetch stage.
package if_stage_pkg;

    localparam int   StallBus    = 6;
    localparam int   BR_WD       = 33;
    localparam int   IF_TO_ID_WD = 33;
    localparam logic Stop        = 1'b1;
    localparam logic NoStop      = 1'b0;

    typedef enum logic {
        CE_OFF = 1'b0,
        CE_RUN = 1'b1
    } ce_state_e;

    function automatic logic misaligned(input logic [31:0] addr);
        return addr[1:0] != 2'b00;
    endfunction

endpackage

// File: rtl/if_stage.sv
// Instruction-fetch stage: owns the PC, issues one SRAM fetch per unstalled cycle and
// holds a branch redirect that arrives during a stall until the PC is free to move.
module if_stage
    import if_stage_pkg::*;
#(
    parameter logic [31:0] RESET_PC = 32'hBFC0_0000
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic [StallBus-1:0]    stall,
    input  logic [BR_WD-1:0]       br_bus,
    output logic [IF_TO_ID_WD-1:0] if_to_id_bus,
    output logic                   inst_sram_en,
    output logic [3:0]             inst_sram_wen,
    output logic [31:0]            inst_sram_addr,
    output logic [31:0]            inst_sram_wdata,
    output logic [31:0]            fetch_cnt,
    output logic                   addr_err
);

    ce_state_e   r_state;
    logic [31:0] r_pc;
    logic        r_pend_v;
    logic [31:0] r_pend_addr;
    logic [31:0] r_fetch_cnt;
    logic        r_addr_err;

    ce_state_e   w_state_nxt;
    logic [31:0] w_pc_nxt;
    logic        w_pend_v_nxt;
    logic [31:0] w_pend_addr_nxt;
    logic [31:0] w_fetch_cnt_nxt;
    logic        w_addr_err_nxt;

    logic        w_br_e;
    logic [31:0] w_br_addr;
    logic        w_stop;
    logic [31:0] w_pc_target;
    logic        w_unused_stall;

    assign w_br_e         = br_bus[32];
    assign w_br_addr      = br_bus[31:0];
    assign w_stop         = (stall[0] == Stop);
    assign w_unused_stall = ^stall[StallBus-1:1];

    // Live branch beats a held redirect, which beats sequential fetch.
    assign w_pc_target = w_br_e   ? w_br_addr   :
                         r_pend_v ? r_pend_addr :
                                    r_pc + 32'd4;

    always_comb begin
        w_state_nxt     = r_state;
        w_pc_nxt        = r_pc;
        w_pend_v_nxt    = r_pend_v;
        w_pend_addr_nxt = r_pend_addr;
        w_fetch_cnt_nxt = r_fetch_cnt;
        w_addr_err_nxt  = r_addr_err;
        case (r_state)
            CE_OFF: begin
                w_state_nxt    = CE_RUN;
                w_pc_nxt       = RESET_PC;
                w_addr_err_nxt = r_addr_err | misaligned(RESET_PC);
            end
            CE_RUN: begin
                if (w_stop) begin
                    if (w_br_e) begin
                        w_pend_v_nxt    = 1'b1;
                        w_pend_addr_nxt = w_br_addr;
                    end
                end else begin
                    w_pc_nxt        = w_pc_target;
                    w_pend_v_nxt    = 1'b0;
                    w_fetch_cnt_nxt = r_fetch_cnt + 32'd1;
                    w_addr_err_nxt  = r_addr_err | misaligned(w_pc_target);
                end
            end
            default: w_state_nxt = CE_OFF;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state     <= CE_OFF;
            r_pc        <= RESET_PC - 32'd4;
            r_pend_v    <= 1'b0;
            r_pend_addr <= 32'd0;
            r_fetch_cnt <= 32'd0;
            r_addr_err  <= 1'b0;
        end else begin
            r_state     <= w_state_nxt;
            r_pc        <= w_pc_nxt;
            r_pend_v    <= w_pend_v_nxt;
            r_pend_addr <= w_pend_addr_nxt;
            r_fetch_cnt <= w_fetch_cnt_nxt;
            r_addr_err  <= w_addr_err_nxt;
        end
    end

    assign inst_sram_en    = (r_state == CE_RUN);
    assign inst_sram_addr  = r_pc;
    assign if_to_id_bus    = {inst_sram_en, r_pc};
    assign inst_sram_wen   = 4'b0000;
    assign inst_sram_wdata = 32'd0;
    assign fetch_cnt       = r_fetch_cnt;
    assign addr_err        = r_addr_err;

endmodule

// File: tb/tb_if_stage.sv
// Directed bench for if_stage: per-cycle comparison against a behavioural fetch model,
// plus literal expectations taken from hand-traced fetch sequences.
module tb_if_stage;

    localparam logic [31:0] RST_PC = 32'hBFC0_0000;

    logic        clk;
    logic        rst;
    logic [5:0]  stall;
    logic [32:0] br_bus;
    logic [32:0] if_to_id_bus;
    logic        inst_sram_en;
    logic [3:0]  inst_sram_wen;
    logic [31:0] inst_sram_addr;
    logic [31:0] inst_sram_wdata;
    logic [31:0] fetch_cnt;
    logic        addr_err;

    int checks = 0;
    int errors = 0;
    bit cmp_en = 0;

    if_stage #(.RESET_PC(RST_PC)) dut (
        .clk             (clk),
        .rst             (rst),
        .stall           (stall),
        .br_bus          (br_bus),
        .if_to_id_bus    (if_to_id_bus),
        .inst_sram_en    (inst_sram_en),
        .inst_sram_wen   (inst_sram_wen),
        .inst_sram_addr  (inst_sram_addr),
        .inst_sram_wdata (inst_sram_wdata),
        .fetch_cnt       (fetch_cnt),
        .addr_err        (addr_err)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Behavioural model: what the fetch stage must present after each edge.
    bit          m_on;
    logic [31:0] m_pc;
    bit          m_hold_v;
    logic [31:0] m_hold_a;
    logic [31:0] m_cnt;
    bit          m_err;

    always @(posedge clk) begin
        if (rst) begin
            m_on = 0; m_pc = RST_PC - 32'd4; m_hold_v = 0; m_hold_a = 0; m_cnt = 0; m_err = 0;
        end else if (!m_on) begin
            m_on = 1; m_pc = RST_PC;
        end else if (stall[0] == 1'b0) begin
            if (br_bus[32])    m_pc = br_bus[31:0];
            else if (m_hold_v) m_pc = m_hold_a;
            else               m_pc = m_pc + 32'd4;
            m_hold_v = 0;
            m_cnt    = m_cnt + 32'd1;
            if (m_pc[1:0] != 2'b00) m_err = 1;
        end else if (br_bus[32]) begin
            m_hold_v = 1; m_hold_a = br_bus[31:0];
        end
    end

    task automatic check(input string name, input logic [32:0] act, input logic [32:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    always @(negedge clk) begin
        if (cmp_en) begin
            check("model_bus",   if_to_id_bus, {m_on, m_pc});
            check("model_en",    {32'd0, inst_sram_en}, {32'd0, m_on});
            check("model_addr",  {1'b0, inst_sram_addr}, {1'b0, m_pc});
            check("model_cnt",   {1'b0, fetch_cnt}, {1'b0, m_cnt});
            check("model_err",   {32'd0, addr_err}, {32'd0, m_err});
            check("model_wen",   {29'd0, inst_sram_wen}, 33'd0);
            check("model_wdata", {1'b0, inst_sram_wdata}, 33'd0);
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk_addr(input string name, input logic [31:0] exp);
        check(name, {1'b0, inst_sram_addr}, {1'b0, exp});
    endtask

    logic [31:0] saved_cnt;

    initial begin
        rst = 1'b1; stall = 6'd0; br_bus = 33'd0;
        step(); step();
        cmp_en = 1;
        check("rst_bus", if_to_id_bus, {1'b0, 32'hBFBF_FFFC});
        check("rst_en",  {32'd0, inst_sram_en}, 33'd0);
        check("rst_cnt", {1'b0, fetch_cnt}, 33'd0);
        check("rst_err", {32'd0, addr_err}, 33'd0);

        rst = 1'b0;
        #1;
        check("cycle0_en", {32'd0, inst_sram_en}, 33'd0);
        step();
        check("cycle1_en", {32'd0, inst_sram_en}, 33'd1);
        for (int i = 0; i < 4; i++) begin
            chk_addr("free_run", 32'hBFC0_0000 + 32'(4 * i));
            step();
        end
        check("free_cnt", {1'b0, fetch_cnt}, 33'd4);
        chk_addr("free_next", 32'hBFC0_0010);

        br_bus = {1'b1, 32'hBFC0_0100};
        step();
        br_bus = 33'd0;
        chk_addr("branch", 32'hBFC0_0100);
        step();
        chk_addr("delay_next", 32'hBFC0_0104);

        saved_cnt = fetch_cnt;
        stall = 6'b000001;
        step();
        br_bus = {1'b1, 32'hBFC0_0200};
        step();
        br_bus = 33'd0;
        step();
        chk_addr("stall_hold", 32'hBFC0_0104);
        check("stall_cnt", {1'b0, fetch_cnt}, {1'b0, saved_cnt});
        stall = 6'd0;
        step();
        chk_addr("pend_apply", 32'hBFC0_0200);
        step();
        chk_addr("pend_clear", 32'hBFC0_0204);

        stall = 6'b111111;
        br_bus = {1'b1, 32'hBFC0_0200};
        step();
        br_bus = 33'd0;
        step();
        stall = 6'b111110;
        br_bus = {1'b1, 32'hBFC0_0300};
        step();
        br_bus = 33'd0;
        chk_addr("live_wins", 32'hBFC0_0300);
        step();
        chk_addr("live_next", 32'hBFC0_0304);

        br_bus = {1'b1, 32'hFFFF_FFFC};
        step();
        br_bus = 33'd0;
        step();
        chk_addr("wrap", 32'h0000_0000);
        check("wrap_err", {32'd0, addr_err}, 33'd0);

        br_bus = {1'b1, 32'hBFC0_0102};
        step();
        br_bus = 33'd0;
        chk_addr("misalign", 32'hBFC0_0102);
        check("misalign_err", {32'd0, addr_err}, 33'd1);
        step();
        step();
        chk_addr("misalign_next", 32'hBFC0_010A);
        check("err_sticky", {32'd0, addr_err}, 33'd1);

        stall = 6'b000001;
        br_bus = {1'b1, 32'hBFC0_0400};
        step();
        br_bus = 33'd0;
        rst = 1'b1;
        step();
        check("midrst_bus", if_to_id_bus, {1'b0, 32'hBFBF_FFFC});
        check("midrst_err", {32'd0, addr_err}, 33'd0);
        check("midrst_cnt", {1'b0, fetch_cnt}, 33'd0);
        rst = 1'b0;
        stall = 6'd0;
        step();
        chk_addr("refetch", 32'hBFC0_0000);
        step();
        chk_addr("refetch_next", 32'hBFC0_0004);
        step();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
